// File: rtl/seq_shifter_pkg.sv
// Shared encodings for the sequential shifter: shift modes (also used by the
// ALU decoder) and the IDLE/SHIFT/DONE controller states.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } sh_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_shifter_step.sv
// shift_step: combinational single-step shift of a word by k <= STEP_BITS bits.
// Rotate datapath exists only when SEQ_SHIFTER_ROTATE_EN is defined; otherwise mode 11 acts as SLL.
module shift_step
    import shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K_W        = 3
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            mode,
    input  logic [K_W-1:0]        k,
    output logic [DATA_WIDTH-1:0] data_out
);

`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [2*DATA_WIDTH-1:0] dbl_s;
`endif

    // One shift step in the requested mode
    always_comb begin
        data_out = data_in;
`ifdef SEQ_SHIFTER_ROTATE_EN
        dbl_s    = {data_in, data_in} << k;
`endif
        case (mode)
            SH_SLL: data_out = data_in << k;
            SH_SRL: data_out = data_in >> k;
            // MSB of the working word still equals the latched operand's sign bit
            SH_SRA: data_out = $unsigned($signed(data_in) >>> k);
`ifdef SEQ_SHIFTER_ROTATE_EN
            SH_ROL: data_out = dbl_s[2*DATA_WIDTH-1:DATA_WIDTH];
`else
            SH_ROL: data_out = data_in << k;
`endif
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter with start/busy/done handshake, up to STEP_BITS per clock.
// Mode 11 rotates left only when SEQ_SHIFTER_ROTATE_EN is defined (otherwise SLL).
module seq_shifter
    import shifter_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int STEP_BITS  = 4,
    localparam int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [SHAMT_W-1:0]    shamt,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int K_W = $clog2(STEP_BITS + 1);

    state_e                state_r;
    logic [DATA_WIDTH-1:0] work_r;
    logic [SHAMT_W-1:0]    rem_r;
    logic [1:0]            mode_r;
    logic [K_W-1:0]        k_s;
    logic [SHAMT_W-1:0]    rem_next_s;
    logic [DATA_WIDTH-1:0] step_out_s;

    // Step size for this cycle: whatever remains, capped at STEP_BITS
    always_comb begin
        if (rem_r < SHAMT_W'(STEP_BITS)) begin
            k_s = rem_r[K_W-1:0];
        end else begin
            k_s = K_W'(STEP_BITS);
        end
        rem_next_s = rem_r - SHAMT_W'(k_s);
    end

    shift_step #(
        .DATA_WIDTH(DATA_WIDTH),
        .K_W       (K_W)
    ) u_step (
        .data_in (work_r),
        .mode    (mode_r),
        .k       (k_s),
        .data_out(step_out_s)
    );

    // Controller, working registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            work_r   <= '0;
            rem_r    <= '0;
            mode_r   <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        work_r <= data_in;
                        mode_r <= mode;
                        rem_r  <= shamt;
                        if (shamt == SHAMT_W'(0)) begin
                            data_out <= data_in;
                            done     <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            busy    <= 1'b1;
                            state_r <= SHIFT;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    work_r <= step_out_s;
                    rem_r  <= rem_next_s;
                    if (rem_next_s == SHAMT_W'(0)) begin
                        data_out <= step_out_s;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= DONE;
                    end else begin
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
